// File: rtl/spare_alloc_sequencer_pkg.sv
// Shared types and field-layout helpers for the spare-allocation search engine.
package spare_alloc_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, EVAL, DONE} state_e;

    // Pivot entry {valid, row, col}; col sits in the LSBs.
    function automatic int piv_w(input int addr_w);
        return 1 + 2 * addr_w;
    endfunction
    function automatic int piv_row_lsb(input int addr_w);
        return addr_w;
    endfunction
    function automatic int piv_vld_bit(input int addr_w);
        return 2 * addr_w;
    endfunction

    // Non-pivot entry {valid, dir, ptr, addr}; addr sits in the LSBs.
    function automatic int np_ptr_w(input int pcam);
        return $clog2(pcam);
    endfunction
    function automatic int np_w(input int pcam, input int addr_w);
        return 2 + $clog2(pcam) + addr_w;
    endfunction
    function automatic int np_ptr_lsb(input int addr_w);
        return addr_w;
    endfunction
    function automatic int np_dir_bit(input int pcam, input int addr_w);
        return addr_w + $clog2(pcam);
    endfunction
    function automatic int np_vld_bit(input int pcam, input int addr_w);
        return addr_w + $clog2(pcam) + 1;
    endfunction

    function automatic int cnt_w(input int nent);
        return $clog2(nent + 1);
    endfunction

    function automatic int popcount(input logic [63:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 64; i++) n += int'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/spare_alloc_sequencer_if.sv
// Request/result bundle between the fault CAMs, the search engine and the signature register.
interface spare_alloc_sequencer_if
    import spare_alloc_pkg::*;
#(
    parameter int PCAM   = 8,
    parameter int NPCAM  = 30,
    parameter int ADDR_W = 10,
    parameter int NSPARE = 4
);
    localparam int PIV_W = piv_w(ADDR_W);
    localparam int NP_W  = np_w(PCAM, ADDR_W);
    localparam int CNT_W = cnt_w(PCAM + NPCAM);

    logic                     start;
    logic [PCAM*PIV_W-1:0]    pivot_fault_addr;
    logic [NPCAM*NP_W-1:0]    nonpivot_fault_addr;
    logic [PCAM-1:0]          dsss;
    logic                     busy;
    logic                     done;
    logic                     found;
    logic                     err;
    logic [NSPARE-1:0]        rlss_out;
    logic [CNT_W-1:0]         uncover_cnt;
    logic [NPCAM-1:0]         nonpivot_cover_result;

    modport master (
        output start, pivot_fault_addr, nonpivot_fault_addr, dsss,
        input  busy, done, found, err, rlss_out, uncover_cnt, nonpivot_cover_result
    );
    modport slave (
        input  start, pivot_fault_addr, nonpivot_fault_addr, dsss,
        output busy, done, found, err, rlss_out, uncover_cnt, nonpivot_cover_result
    );
endinterface

// File: rtl/spare_alloc_sequencer_cover.sv
// Per-fault cover check against the spare lines of the current candidate.
module sa_cover_cmp
    import spare_alloc_pkg::*;
#(
    parameter int NSPARE = 4,
    parameter int ADDR_W = 10
) (
    input  logic                           fault_vld,
    input  logic [ADDR_W-1:0]              fault_row,
    input  logic [ADDR_W-1:0]              fault_col,
    input  logic [NSPARE-1:0][ADDR_W-1:0]  sp_addr,
    input  logic [NSPARE-1:0]              sp_is_row,
    input  logic [NSPARE-1:0]              sp_en,
    output logic                           covered
);
    // A fault that does not need repair counts as covered; otherwise any enabled matching spare covers it.
    always_comb begin
        covered = ~fault_vld;
        for (int k = 0; k < NSPARE; k++) begin
            if (sp_en[k] && (sp_is_row[k] ? (fault_row == sp_addr[k]) : (fault_col == sp_addr[k])))
                covered = 1'b1;
        end
    end
endmodule

// File: rtl/spare_alloc_sequencer.sv
// Sequenced spare-allocation search: one row/column assignment evaluated per clock.
module spare_alloc_sequencer
    import spare_alloc_pkg::*;
#(
    parameter int PCAM   = 8,
    parameter int NPCAM  = 30,
    parameter int ADDR_W = 10,
    parameter int NSPARE = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    spare_alloc_sequencer_if.slave  sif
);
    localparam int PIV_W   = piv_w(ADDR_W);
    localparam int PIV_ROW = piv_row_lsb(ADDR_W);
    localparam int PIV_VLD = piv_vld_bit(ADDR_W);
    localparam int PTR_W   = np_ptr_w(PCAM);
    localparam int NP_W    = np_w(PCAM, ADDR_W);
    localparam int NP_PTR  = np_ptr_lsb(ADDR_W);
    localparam int NP_DIR  = np_dir_bit(PCAM, ADDR_W);
    localparam int NP_VLD  = np_vld_bit(PCAM, ADDR_W);
    localparam int NENT    = PCAM + NPCAM;
    localparam int CNT_W   = cnt_w(NENT);

    state_e                          state_q, state_d;
    logic [NSPARE-1:0]               cand_q, cand_d;
    logic [PCAM*PIV_W-1:0]           piv_q, piv_d;
    logic [NPCAM*NP_W-1:0]           np_q, np_d;
    logic [PCAM-1:0]                 dsss_q, dsss_d;
    logic [NSPARE-1:0][ADDR_W-1:0]   sp_row_q, sp_row_d, sp_col_q, sp_col_d;
    logic [NSPARE-1:0]               sp_en_q, sp_en_d;
    logic [NSPARE-1:0]               best_cand_q, best_cand_d;
    logic [CNT_W-1:0]                best_cnt_q, best_cnt_d;
    logic [NPCAM-1:0]                best_cov_q, best_cov_d;
    logic                            busy_q, busy_d, done_q, done_d;
    logic                            found_q, found_d, err_q, err_d;
    logic [NSPARE-1:0]               rlss_q, rlss_d;
    logic [CNT_W-1:0]                ucnt_q, ucnt_d;
    logic [NPCAM-1:0]                npcov_q, npcov_d;

    logic [PCAM-1:0]                 p_vld;
    logic [PCAM-1:0][ADDR_W-1:0]     p_row, p_col;
    logic [NENT-1:0]                 f_vld;
    logic [NENT-1:0][ADDR_W-1:0]     f_row, f_col;
    logic [NSPARE-1:0][ADDR_W-1:0]   bind_row, bind_col, sp_addr;
    logic [NSPARE-1:0]               bind_en;
    logic [NENT-1:0]                 cov;
    logic [CNT_W-1:0]                ucnt;
    logic                            err_c, take_cur;
    logic [NSPARE-1:0]               nb_cand;
    logic [CNT_W-1:0]                nb_cnt;
    logic [NPCAM-1:0]                nb_cov;

    // Unpack the snapshot into fault coordinates; must-repair pivots are pre-covered.
    always_comb begin
        for (int i = 0; i < PCAM; i++) begin
            p_vld[i] = piv_q[i*PIV_W + PIV_VLD];
            p_row[i] = piv_q[i*PIV_W + PIV_ROW +: ADDR_W];
            p_col[i] = piv_q[i*PIV_W +: ADDR_W];
            f_vld[i] = p_vld[i] & ~dsss_q[i];
            f_row[i] = p_row[i];
            f_col[i] = p_col[i];
        end
        for (int j = 0; j < NPCAM; j++) begin
            f_vld[PCAM+j] = np_q[j*NP_W + NP_VLD];
            if (np_q[j*NP_W + NP_DIR]) begin
                f_row[PCAM+j] = np_q[j*NP_W +: ADDR_W];
                f_col[PCAM+j] = p_col[np_q[j*NP_W + NP_PTR +: PTR_W]];
            end else begin
                f_row[PCAM+j] = p_row[np_q[j*NP_W + NP_PTR +: PTR_W]];
                f_col[PCAM+j] = np_q[j*NP_W +: ADDR_W];
            end
        end
    end

    // Bind spare k to the k-th must-repair pivot, lowest index first.
    always_comb begin
        int nb;
        nb       = 0;
        bind_row = '0;
        bind_col = '0;
        bind_en  = '0;
        for (int i = 0; i < PCAM; i++) begin
            if (dsss_q[i]) begin
                for (int k = 0; k < NSPARE; k++) begin
                    if (nb == k) begin
                        bind_row[k] = p_row[i];
                        bind_col[k] = p_col[i];
                        bind_en[k]  = 1'b1;
                    end
                end
                nb++;
            end
        end
        err_c = popcount(64'(dsss_q)) > NSPARE;
    end

    // Candidate bit k selects the row or column of spare k's pivot.
    always_comb begin
        for (int k = 0; k < NSPARE; k++)
            sp_addr[k] = cand_q[k] ? sp_row_q[k] : sp_col_q[k];
    end

    for (genvar g = 0; g < NENT; g++) begin : g_cov
        sa_cover_cmp #(.NSPARE(NSPARE), .ADDR_W(ADDR_W)) u_cov (
            .fault_vld (f_vld[g]),
            .fault_row (f_row[g]),
            .fault_col (f_col[g]),
            .sp_addr   (sp_addr),
            .sp_is_row (cand_q),
            .sp_en     (sp_en_q),
            .covered   (cov[g])
        );
    end

    // Uncovered count for this candidate and the running best (strict less keeps the lower index on ties).
    always_comb begin
        ucnt = '0;
        for (int i = 0; i < NENT; i++)
            if (!cov[i]) ucnt = ucnt + CNT_W'(1);
        take_cur = (cand_q == '0) || (ucnt < best_cnt_q);
        nb_cand  = take_cur ? cand_q : best_cand_q;
        nb_cnt   = take_cur ? ucnt : best_cnt_q;
        nb_cov   = take_cur ? cov[NENT-1:PCAM] : best_cov_q;
    end

    // Search FSM: snapshot, bind, step candidates, publish result.
    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        piv_d       = piv_q;
        np_d        = np_q;
        dsss_d      = dsss_q;
        sp_row_d    = sp_row_q;
        sp_col_d    = sp_col_q;
        sp_en_d     = sp_en_q;
        best_cand_d = best_cand_q;
        best_cnt_d  = best_cnt_q;
        best_cov_d  = best_cov_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        found_d     = found_q;
        err_d       = err_q;
        rlss_d      = rlss_q;
        ucnt_d      = ucnt_q;
        npcov_d     = npcov_q;
        unique case (state_q)
            IDLE: if (sif.start) begin
                state_d = LOAD;
                piv_d   = sif.pivot_fault_addr;
                np_d    = sif.nonpivot_fault_addr;
                dsss_d  = sif.dsss;
                busy_d  = 1'b1;
                found_d = 1'b0;
                err_d   = 1'b0;
                rlss_d  = '0;
                ucnt_d  = '0;
                npcov_d = '0;
            end
            LOAD: begin
                sp_row_d = bind_row;
                sp_col_d = bind_col;
                sp_en_d  = bind_en;
                cand_d   = '0;
                if (err_c) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    state_d = EVAL;
                end
            end
            EVAL: begin
                best_cand_d = nb_cand;
                best_cnt_d  = nb_cnt;
                best_cov_d  = nb_cov;
                if (ucnt == '0 || cand_q == '1) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    found_d = (ucnt == '0);
                    rlss_d  = nb_cand;
                    ucnt_d  = nb_cnt;
                    npcov_d = nb_cov;
                end else begin
                    cand_d = cand_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                cand_d  = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any search in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cand_q      <= '0;
            piv_q       <= '0;
            np_q        <= '0;
            dsss_q      <= '0;
            sp_row_q    <= '0;
            sp_col_q    <= '0;
            sp_en_q     <= '0;
            best_cand_q <= '0;
            best_cnt_q  <= '0;
            best_cov_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            found_q     <= 1'b0;
            err_q       <= 1'b0;
            rlss_q      <= '0;
            ucnt_q      <= '0;
            npcov_q     <= '0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            piv_q       <= piv_d;
            np_q        <= np_d;
            dsss_q      <= dsss_d;
            sp_row_q    <= sp_row_d;
            sp_col_q    <= sp_col_d;
            sp_en_q     <= sp_en_d;
            best_cand_q <= best_cand_d;
            best_cnt_q  <= best_cnt_d;
            best_cov_q  <= best_cov_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            found_q     <= found_d;
            err_q       <= err_d;
            rlss_q      <= rlss_d;
            ucnt_q      <= ucnt_d;
            npcov_q     <= npcov_d;
        end
    end

    assign sif.busy                  = busy_q;
    assign sif.done                  = done_q;
    assign sif.found                 = found_q;
    assign sif.err                   = err_q;
    assign sif.rlss_out              = rlss_q;
    assign sif.uncover_cnt           = ucnt_q;
    assign sif.nonpivot_cover_result = npcov_q;

endmodule

// File: tb/tb_spare_alloc_sequencer.sv
// Directed and randomized checks of the spare-allocation search against a brute-force reference.
module tb_spare_alloc_sequencer;
    localparam int PCAM = 8, NPCAM = 30, ADDR_W = 10, NSPARE = 4;
    localparam int PTR_W = 3, NCAND = 16, CNT_W = 6, PIV_W = 21, NP_W = 15;

    typedef struct packed {
        logic              found;
        logic              err;
        logic [NSPARE-1:0] rlss;
        logic [CNT_W-1:0]  ucnt;
        logic [NPCAM-1:0]  npcov;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spare_alloc_sequencer_if #(.PCAM(PCAM), .NPCAM(NPCAM), .ADDR_W(ADDR_W), .NSPARE(NSPARE)) sif ();
    spare_alloc_sequencer #(.PCAM(PCAM), .NPCAM(NPCAM), .ADDR_W(ADDR_W), .NSPARE(NSPARE)) dut (
        .clk(clk), .rst_n(rst_n), .sif(sif)
    );

    int vecs = 0, errs = 0;

    // Fault map as plain arrays.
    int prow[PCAM], pcol[PCAM];
    bit pvld[PCAM];
    bit nvld[NPCAM], ndir[NPCAM];
    int nptr[NPCAM], naddr[NPCAM];
    logic [PCAM-1:0] dsss_m;
    int bnd[NSPARE];
    int nbnd;

    task automatic cfg_clear();
        for (int i = 0; i < PCAM; i++) begin pvld[i] = 0; prow[i] = 0; pcol[i] = 0; end
        for (int j = 0; j < NPCAM; j++) begin nvld[j] = 0; ndir[j] = 0; nptr[j] = 0; naddr[j] = 0; end
        dsss_m = '0;
    endtask

    task automatic cfg_row_only();
        cfg_clear();
        pvld[0] = 1; prow[0] = 5; pcol[0] = 9; dsss_m = 8'b0000_0001;
        for (int j = 0; j < 6; j++) begin nvld[j] = 1; ndir[j] = 0; nptr[j] = 0; naddr[j] = 100 + j; end
    endtask

    task automatic cfg_col_only();
        cfg_clear();
        pvld[0] = 1; prow[0] = 5; pcol[0] = 9; dsss_m = 8'b0000_0001;
        for (int j = 0; j < 6; j++) begin nvld[j] = 1; ndir[j] = 1; nptr[j] = 0; naddr[j] = 200 + j; end
    endtask

    task automatic cfg_infeasible();
        cfg_clear();
        pvld[0] = 1; prow[0] = 5;   pcol[0] = 9;
        pvld[1] = 1; prow[1] = 12;  pcol[1] = 20;
        pvld[2] = 0; prow[2] = 700; pcol[2] = 700;
        dsss_m = 8'b0000_0011;
        nvld[0] = 1; ndir[0] = 0; nptr[0] = 2; naddr[0] = 700;
        nvld[1] = 1; ndir[1] = 0; nptr[1] = 0; naddr[1] = 33;
        nvld[2] = 1; ndir[2] = 1; nptr[2] = 1; naddr[2] = 44;
    endtask

    task automatic cfg_random();
        dsss_m = 8'($urandom) & 8'($urandom);
        for (int i = 0; i < PCAM; i++) begin
            pvld[i] = 1'($urandom_range(0, 1));
            prow[i] = $urandom_range(0, 3);
            pcol[i] = $urandom_range(0, 3);
        end
        for (int j = 0; j < NPCAM; j++) begin
            nvld[j]  = ($urandom_range(0, 2) == 0);
            ndir[j]  = 1'($urandom_range(0, 1));
            nptr[j]  = $urandom_range(0, PCAM - 1);
            naddr[j] = $urandom_range(0, 3);
        end
    endtask

    task automatic drive_cfg();
        for (int i = 0; i < PCAM; i++)
            sif.pivot_fault_addr[i*PIV_W +: PIV_W] = {pvld[i], ADDR_W'(prow[i]), ADDR_W'(pcol[i])};
        for (int j = 0; j < NPCAM; j++)
            sif.nonpivot_fault_addr[j*NP_W +: NP_W] = {nvld[j], ndir[j], PTR_W'(nptr[j]), ADDR_W'(naddr[j])};
        sif.dsss = dsss_m;
    endtask

    function automatic bit hit(input int c, input int r, input int col);
        for (int k = 0; k < nbnd; k++) begin
            if (((c >> k) & 1) == 1) begin
                if (prow[bnd[k]] == r) return 1;
            end else begin
                if (pcol[bnd[k]] == col) return 1;
            end
        end
        return 0;
    endfunction

    // Brute force over all assignments; first full cover wins, otherwise lowest-index minimum.
    task automatic model(output res_t r, output int lat);
        int bestu;
        bit fnd;
        r = '0;
        nbnd = 0;
        for (int i = 0; i < PCAM; i++) begin
            if (dsss_m[i]) begin
                if (nbnd < NSPARE) bnd[nbnd] = i;
                nbnd++;
            end
        end
        if (nbnd > NSPARE) begin
            r.err = 1'b1;
            lat = 1;
            return;
        end
        bestu = 1 << 30;
        fnd = 0;
        lat = 1 + NCAND;
        for (int c = 0; c < NCAND && !fnd; c++) begin
            int u;
            logic [NPCAM-1:0] cv;
            u = 0;
            cv = '0;
            for (int i = 0; i < PCAM; i++)
                if (pvld[i] && !dsss_m[i] && !hit(c, prow[i], pcol[i])) u++;
            for (int j = 0; j < NPCAM; j++) begin
                if (!nvld[j]) cv[j] = 1'b1;
                else if (ndir[j]) cv[j] = hit(c, naddr[j], pcol[nptr[j]]);
                else cv[j] = hit(c, prow[nptr[j]], naddr[j]);
                if (!cv[j]) u++;
            end
            if (u < bestu) begin
                bestu = u;
                r.rlss = NSPARE'(c);
                r.ucnt = CNT_W'(u);
                r.npcov = cv;
            end
            if (u == 0) begin
                fnd = 1;
                r.found = 1'b1;
                lat = 2 + c;
            end
        end
    endtask

    function automatic res_t dut_res();
        return {sif.found, sif.err, sif.rlss_out, sif.uncover_cnt, sif.nonpivot_cover_result};
    endfunction

    // Call just after edge 0; returns the edge number after which done was seen (-1 on timeout).
    task automatic wait_done(input bit hold, output int lat, output logic busy0);
        lat = -1;
        busy0 = 1'b0;
        for (int e = 0; e < 60; e++) begin
            @(negedge clk);
            if (e == 0) begin sif.start = hold; busy0 = sif.busy; end
            if (sif.done) begin lat = e; break; end
            @(posedge clk);
        end
    endtask

    task automatic launch_wait(input bit hold, output int lat, output logic busy0);
        @(negedge clk);
        sif.start = 1'b1;
        @(posedge clk);
        wait_done(hold, lat, busy0);
    endtask

    task automatic test_reset();
        sif.start = 1'b0;
        cfg_clear();
        drive_cfg();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vecs++;
        if ({sif.busy, sif.done, dut_res()} !== '0) begin
            errs++;
            $display("FAIL reset_state: got %h want 0", {sif.busy, sif.done, dut_res()});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_row_only();
        res_t er, got; int el, lat; logic b0;
        cfg_row_only(); drive_cfg(); model(er, el);
        launch_wait(1'b0, lat, b0);
        got = dut_res();
        vecs++; if (got !== er) begin errs++; $display("FAIL row_only result: got %h want %h", got, er); end
        vecs++; if (lat !== el) begin errs++; $display("FAIL row_only latency: got %0d want %0d", lat, el); end
        vecs++; if (got.rlss !== 4'b0001 || lat !== 3) begin errs++; $display("FAIL row_only anchor: rlss %b lat %0d want 0001/3", got.rlss, lat); end
        vecs++; if (b0 !== 1'b1) begin errs++; $display("FAIL row_only busy: got %b want 1", b0); end
    endtask

    task automatic test_col_only();
        res_t er, got; int el, lat; logic b0;
        cfg_col_only(); drive_cfg(); model(er, el);
        launch_wait(1'b0, lat, b0);
        got = dut_res();
        vecs++; if (got !== er) begin errs++; $display("FAIL col_only result: got %h want %h", got, er); end
        vecs++; if (lat !== 2 || got.found !== 1'b1 || got.rlss !== 4'b0000) begin
            errs++; $display("FAIL col_only anchor: lat %0d found %b rlss %b want 2/1/0000", lat, got.found, got.rlss); end
    endtask

    task automatic test_infeasible();
        res_t er, got; int el, lat; logic b0;
        cfg_infeasible(); drive_cfg(); model(er, el);
        launch_wait(1'b0, lat, b0);
        got = dut_res();
        vecs++; if (got !== er) begin errs++; $display("FAIL infeasible result: got %h want %h", got, er); end
        vecs++; if (lat !== 17 || got.found !== 1'b0 || got.ucnt !== 6'd1) begin
            errs++; $display("FAIL infeasible anchor: lat %0d found %b ucnt %0d want 17/0/1", lat, got.found, got.ucnt); end
    endtask

    task automatic test_err();
        res_t got; int lat; logic b0;
        cfg_clear();
        for (int i = 0; i < 5; i++) begin pvld[i] = 1; prow[i] = i; pcol[i] = 10 + i; end
        dsss_m = 8'h1F;
        drive_cfg();
        launch_wait(1'b0, lat, b0);
        got = dut_res();
        vecs++; if (got !== res_t'({1'b0, 1'b1, {(NSPARE+CNT_W+NPCAM){1'b0}}})) begin
            errs++; $display("FAIL err_result: got %h want err only", got); end
        vecs++; if (lat !== 1) begin errs++; $display("FAIL err_latency: got %0d want 1", lat); end
    endtask

    task automatic test_reset_mid();
        res_t er, got; int el, lat; logic b0;
        cfg_infeasible(); drive_cfg(); model(er, el);
        @(negedge clk); sif.start = 1'b1;
        @(posedge clk);
        @(negedge clk); sif.start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        vecs++;
        if ({sif.busy, sif.done, dut_res()} !== '0) begin
            errs++; $display("FAIL reset_mid: got %h want 0", {sif.busy, sif.done, dut_res()});
        end
        rst_n = 1'b1;
        sif.start = 1'b1;
        @(posedge clk);
        wait_done(1'b0, lat, b0);
        got = dut_res();
        vecs++; if (got !== er || lat !== el) begin
            errs++; $display("FAIL restart: got %h lat %0d want %h lat %0d", got, lat, er, el); end
    endtask

    task automatic test_back_to_back();
        res_t er1, er2, g1, g2; int el1, el2, d1, d2;
        cfg_row_only(); drive_cfg(); model(er1, el1);
        cfg_col_only(); model(er2, el2);
        d1 = -1; d2 = -1; g1 = '0; g2 = '0;
        @(negedge clk); sif.start = 1'b1;
        @(posedge clk);
        for (int e = 0; e < 60; e++) begin
            @(negedge clk);
            if (e == 0) drive_cfg();
            if (sif.done) begin
                if (d1 < 0) begin d1 = e; g1 = dut_res(); end
                else begin d2 = e; g2 = dut_res(); break; end
            end
            @(posedge clk);
        end
        sif.start = 1'b0;
        vecs++; if (g1 !== er1 || d1 !== el1) begin
            errs++; $display("FAIL b2b_first: got %h at %0d want %h at %0d", g1, d1, er1, el1); end
        vecs++; if (g2 !== er2 || d2 !== el1 + 2 + el2) begin
            errs++; $display("FAIL b2b_second: got %h at %0d want %h at %0d", g2, d2, er2, el1 + 2 + el2); end
    endtask

    task automatic test_ignore_start();
        res_t er, got; int el, lat; logic b0;
        cfg_infeasible(); drive_cfg(); model(er, el);
        lat = -1;
        @(negedge clk); sif.start = 1'b1;
        @(posedge clk);
        for (int e = 0; e < 60; e++) begin
            @(negedge clk);
            sif.start = (e == 3 || e == 6 || e == 10);
            if (sif.done) begin lat = e; break; end
            @(posedge clk);
        end
        got = dut_res();
        vecs++; if (got !== er || lat !== el) begin
            errs++; $display("FAIL ignore_start: got %h lat %0d want %h lat %0d", got, lat, er, el); end
        repeat (3) @(negedge clk);
        got = dut_res();
        vecs++; if (got !== er || sif.busy !== 1'b0) begin
            errs++; $display("FAIL result_hold: got %h busy %b want %h busy 0", got, sif.busy, er); end
        cfg_col_only(); drive_cfg(); model(er, el);
        sif.start = 1'b1;
        @(posedge clk);
        @(negedge clk); sif.start = 1'b0;
        vecs++; if (dut_res() !== '0 || sif.busy !== 1'b1) begin
            errs++; $display("FAIL clear_on_load: got %h busy %b want 0 busy 1", dut_res(), sif.busy); end
        lat = -1;
        for (int e = 1; e < 60; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (sif.done) begin lat = e; break; end
        end
        vecs++; if (dut_res() !== er || lat !== el) begin
            errs++; $display("FAIL after_clear: got %h lat %0d want %h lat %0d", dut_res(), lat, er, el); end
    endtask

    task automatic test_random();
        res_t er, got; int el, lat; logic b0;
        for (int n = 0; n < 40; n++) begin
            cfg_random(); drive_cfg(); model(er, el);
            launch_wait(1'b0, lat, b0);
            got = dut_res();
            vecs++; if (got !== er) begin errs++; $display("FAIL random_%0d result: got %h want %h", n, got, er); end
            vecs++; if (lat !== el) begin errs++; $display("FAIL random_%0d latency: got %0d want %0d", n, lat, el); end
        end
    endtask

    initial begin
        sif.start = 1'b0;
        sif.pivot_fault_addr = '0;
        sif.nonpivot_fault_addr = '0;
        sif.dsss = '0;
        test_reset();
        test_row_only();
        test_col_only();
        test_infeasible();
        test_err();
        test_reset_mid();
        test_back_to_back();
        test_ignore_start();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/spare_alloc_sequencer.md
# spare_alloc_sequencer

Multi-cycle spare-allocation search engine for the BIRA datapath. From a latched snapshot of the pivot and non-pivot fault CAMs and a must-repair pivot mask, it steps through every row/column assignment of the spare lines, one candidate per clock, and reports the first assignment that covers every valid fault. If no assignment covers everything, it reports the assignment that leaves the fewest faults uncovered. It sits between the fault-collection CAMs and the repair-signature register, replacing the single-shot combinational coverage check with a parametrised, sequenced search.

## Interface
- PCAM, 8, number of pivot CAM entries
- NPCAM, 30, number of non-pivot CAM entries
- ADDR_W, 10, row/column address width
- NSPARE, 4, number of spare lines; 2^NSPARE candidates
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low, sampled on rising clk
- start  in  1  begin search; sampled only in IDLE
- pivot_fault_addr  in  PCAM*(1+2*ADDR_W)  per entry {valid, row, col}; entry 0 in the LSBs
- nonpivot_fault_addr  in  NPCAM*(2+$clog2(PCAM)+ADDR_W)  per entry {valid, dir, ptr, addr}
- dsss  in  PCAM  must-repair pivot mask
- busy  out  1  search in progress
- done  out  1  one-cycle completion pulse
- found  out  1  full-cover assignment found
- err  out  1  popcount(dsss) > NSPARE
- rlss_out  out  NSPARE  winning or best assignment; bit k=1 means spare k is a row spare
- uncover_cnt  out  $clog2(PCAM+NPCAM+1)  uncovered valid faults for rlss_out
- nonpivot_cover_result  out  NPCAM  per-entry cover flags for rlss_out

## Operation
- **Snapshot.** On an IDLE cycle with start=1, the block latches both CAM arrays and dsss. Inputs may change afterwards; the search uses only the snapshot.
- **Spare mapping.** Spare k is bound to the k-th set bit of the latched dsss, lowest index first.
  - If rlss bit k=1, spare k is a row spare at that pivot's row; otherwise it is a column spare at that pivot's column.
  - Spares with no bound pivot are disabled and match nothing.
- **Fault coordinates.**
  - A non-pivot entry with dir=0 has row = pivot[ptr].row and col = addr.
  - A non-pivot entry with dir=1 has col = pivot[ptr].col and row = addr.
- **Cover rule.** A fault is covered if its row equals any enabled row spare or its column equals any enabled column spare. dsss-selected pivots are always covered. Invalid entries count as covered.
- **FSM.**
  - IDLE: start → LOAD.
  - LOAD: compute the spare binding. If err → DONE; otherwise → EVAL with cand=0.
  - EVAL: evaluate cand.
    - If uncovered count = 0 → DONE with found=1.
    - Else if cand = 2^NSPARE-1 → DONE with found=0.
    - Else cand+1.
  - DONE: pulse done → IDLE.
- **Best tracking.** During EVAL, the block keeps the candidate with minimum uncovered count; ties go to the lower candidate index. At DONE, rlss_out, uncover_cnt and nonpivot_cover_result reflect either the winning candidate or this best candidate.
- **err case.** When err=1: found=0, rlss_out=0, uncover_cnt=0, nonpivot_cover_result=0.
- **Persistence.** Result outputs hold until the next start is accepted. They clear when LOAD is entered.
- **start while not IDLE** is ignored.

## Timing
- **Reset.** rst_n low at a rising edge forces IDLE and cand=0 and clears every output (busy, done, found, err, rlss_out, uncover_cnt, nonpivot_cover_result) to 0. This applies mid-search too: the search is aborted and no done pulse is produced.
- **Cycle numbering.** Edge 0 is the edge at which start is sampled.
  - busy=1 from after edge 0 until the edge that enters DONE.
  - Candidate k is registered at edge 2+k.
- **Success at candidate c:** done is high during the cycle after edge 2+c.
- **Exhaustive failure:** done follows edge 1+2^NSPARE (edge 17 for NSPARE=4).
- **err:** done follows edge 1.
- **Back-to-back searches.** done lasts exactly one cycle. A start held high re-launches on the cycle after done (IDLE), so the minimum start-to-start spacing is 3 cycles plus the evaluation cycles.
- **Per-candidate logic.** Cover evaluation for one candidate is single-cycle combinational, followed by the registered compare and best-candidate update. There is no extra pipeline stage.

## Structure
- **Package spare_alloc_pkg** holds:
  - pivot and non-pivot entry field offsets and widths as functions of PCAM and ADDR_W;
  - the FSM state enum {IDLE, LOAD, EVAL, DONE};
  - a popcount function.
- **Sub-module sa_cover_cmp.** One instance per fault entry. It takes the fault row/col and the NSPARE spare addresses, types and enables, and outputs covered. Instantiate it with a generate loop over PCAM+NPCAM.
- **Top level** holds the snapshot registers, spare binder, candidate counter, uncovered-count adder tree, best-candidate registers and the FSM.

## Test plan
- **Row-only cover.** dsss=0b0001, pivot0 row=5, col=9; nonpivots at rows 5 via dir=0 → found=1, rlss_out=0001, done at edge 3 (cand 1).
- **Column-only cover.** dsss=0b0001, all nonpivots dir=1 off pivot0 col=9 → cand 0 wins, found=1, rlss_out=0000, done after edge 2.
- **Infeasible.** dsss=0b00011, uncoverable nonpivot at row 700/col 700 → found=0, done after edge 17, uncover_cnt=1, rlss_out = lowest tied candidate.
- **Too many must-repair pivots.** dsss=0x1F with NSPARE=4 → err=1, found=0, done after edge 1, rlss_out=0.
- **Reset and restart.** rst_n=0 at edge 5 of a running search → all outputs 0, no done; start at the next cycle → fresh search completes normally.
- **Ignored start and hold.** start held high across DONE → second search begins in IDLE; start pulses during EVAL ignored; results hold until LOAD.
